switch_toggle_bank: RTL
=======================

Name: switch_toggle_bank

Overview:
Parametrised multi-channel switch-to-LED toggler for the board's push-buttons.
- Each channel synchronises a raw switch, debounces it with a per-channel counter, and detects a selectable edge.
- On each detected edge it flips a per-channel LED register and emits a one-cycle event pulse.
- Sits directly between board switch pins and LED pins or downstream logic; its pulses feed counters and state machines elsewhere in the design.

Parameters:
NUM_CH, 4, number of independent switch/LED channels (1..8).
DEBOUNCE_LIMIT, 250000, consecutive cycles a new synchronised level must persist before acceptance (>=1; 10 ms at 25 MHz).
EDGE_MODE, 0, qualifying edge: 0 = falling (release), 1 = rising (press), 2 = both.

Ports:
i_Clk  input  1  system clock; all state updates on its rising edge.
i_Rst_L  input  1  asynchronous, active-low reset; clears all state immediately, released synchronously by the board reset logic.
i_Switch  input  NUM_CH  raw asynchronous switch levels, bit n = channel n.
i_Clear  input  1  synchronous clear of all LED toggle registers.
o_LED  output  NUM_CH  per-channel toggle state.
o_Edge_Pulse  output  NUM_CH  one-cycle pulse per qualifying debounced edge.
o_Debounced  output  NUM_CH  debounced switch level.

Behaviour:
- Reset (i_Rst_L=0): sync flops, debounced state, counters, o_LED, o_Edge_Pulse and o_Debounced all 0 asynchronously. Stays held while low.
- Synchroniser: 2-flop chain per channel (r_Sync1 -> r_Sync2). No logic consumes r_Sync1.
- Debounce counter: width $clog2(DEBOUNCE_LIMIT+1), one per channel.
  - r_Sync2 == o_Debounced: counter <= 0.
  - r_Sync2 != o_Debounced and counter < DEBOUNCE_LIMIT-1: counter increments.
  - r_Sync2 != o_Debounced and counter == DEBOUNCE_LIMIT-1: o_Debounced <= r_Sync2, counter <= 0.
  - The counter never wraps.
- Latency: i_Switch stable from sampling edge N → o_Debounced changes at edge N+1+DEBOUNCE_LIMIT.
- Glitch rejection: a pulse on r_Sync2 shorter than DEBOUNCE_LIMIT cycles is rejected and the counter restarts from 0.
- Edge detect, evaluated on the o_Debounced transition at the accepting edge:
  - falling: 1 → 0; rising: 0 → 1; both: either.
  - o_Edge_Pulse[n] is registered and goes high for exactly the one cycle following the accepting edge, then 0.
- Toggle: on a qualifying edge, o_LED[n] <= ~o_LED[n] at the same clock edge that o_Edge_Pulse[n] rises.
- i_Clear=1: all o_LED <= 0 at that edge. If it coincides with a qualifying edge, clear wins (o_LED=0), but o_Edge_Pulse is still emitted. i_Clear does not affect debounce state or o_Debounced.
- Channels are fully independent. Simultaneous edges on several channels all toggle and pulse in the same cycle.
- Reset mid-debounce: count discarded. After release, a held level needs the full N+1+DEBOUNCE_LIMIT latency again. A switch held at 1 through reset produces a rising event after release (it counts as a 0 → 1 transition).
- No combinational path from any input to any output.

Test Plan:
NUM_CH=2, DEBOUNCE_LIMIT=4, EDGE_MODE=0 unless stated.
1. Reset and clear: assert i_Rst_L=0 mid-cycle with o_LED=2'b11 → all outputs 0 immediately, before the next clock edge. Separately, i_Clear=1 for one cycle with o_LED=2'b01 → o_LED=2'b00 next edge, o_Debounced unchanged.
2. Press/release ch0: i_Switch[0] 0→1 at edge N, held 20 cycles, then 1→0 at edge M.
   - o_Debounced[0]=1 at edge N+5; no pulse, o_LED[0]=0.
   - o_Debounced[0]=0 at edge M+5; o_Edge_Pulse[0]=1 for exactly one cycle; o_LED[0]=1.
   - Channel 1 outputs stay 0.
3. Bounce: i_Switch[0] toggles every 2 cycles for 20 cycles, then settles at 0 → o_Debounced[0] never changes; no pulse; o_LED unchanged.
4. EDGE_MODE=2, both channels pressed and released in the same cycles → 2'b11 pulse on each of the 2 accepted edges; o_LED goes 00→11→00.
5. Coincidence: i_Clear=1 on the accepting edge of a falling event with o_LED[0]=0 → o_LED[0]=0, o_Edge_Pulse[0]=1.
6. Reset mid-debounce: release i_Switch[0] (1→0) at edge N; pulse i_Rst_L low at edge N+3 and release it; keep i_Switch[0]=1 from then on → no falling event; o_Debounced[0] rises DEBOUNCE_LIMIT+1 edges after the first post-reset sample; no pulse.

Source files
------------

// File: rtl/switch_toggle_bank.sv
// Multi-channel push-button toggler: each channel synchronises, debounces and
// edge-detects its switch, then flips an LED register and emits a one-cycle pulse.
module switch_toggle_bank #(
    parameter int NUM_CH         = 4,
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int EDGE_MODE      = 0
) (
    input  logic              i_Clk,
    input  logic              i_Rst_L,
    input  logic [NUM_CH-1:0] i_Switch,
    input  logic              i_Clear,
    output logic [NUM_CH-1:0] o_LED,
    output logic [NUM_CH-1:0] o_Edge_Pulse,
    output logic [NUM_CH-1:0] o_Debounced
);

    localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LIMIT - 1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic          sync1_q, sync2_q;
            logic          deb_q, deb_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic          led_q, led_d;
            logic          pulse_q, pulse_d;
            logic          accept;
            logic          qualify;

            // The counter only runs while the synchronised level disagrees
            // with the accepted level; any agreement restarts it from zero.
            always_comb begin
                cnt_d  = cnt_q;
                deb_d  = deb_q;
                accept = 1'b0;
                if (sync2_q == deb_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    deb_d  = sync2_q;
                    cnt_d  = '0;
                    accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_comb begin
                qualify = 1'b0;
                case (EDGE_MODE)
                    0:       qualify = accept & ~sync2_q;
                    1:       qualify = accept &  sync2_q;
                    default: qualify = accept;
                endcase
                pulse_d = qualify;
                // Clear has priority over a coincident toggle; the pulse still fires.
                if (i_Clear)
                    led_d = 1'b0;
                else if (qualify)
                    led_d = ~led_q;
                else
                    led_d = led_q;
            end

            always_ff @(posedge i_Clk or negedge i_Rst_L) begin
                if (!i_Rst_L) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    deb_q   <= 1'b0;
                    cnt_q   <= '0;
                    led_q   <= 1'b0;
                    pulse_q <= 1'b0;
                end else begin
                    sync1_q <= i_Switch[gi];
                    sync2_q <= sync1_q;
                    deb_q   <= deb_d;
                    cnt_q   <= cnt_d;
                    led_q   <= led_d;
                    pulse_q <= pulse_d;
                end
            end

            assign o_LED[gi]        = led_q;
            assign o_Edge_Pulse[gi] = pulse_q;
            assign o_Debounced[gi]  = deb_q;
        end
    endgenerate

endmodule
